// File: rtl/mem_resp_pkg.sv
// rtl/mem_resp_pkg.sv - shared types and constants for the memory responder
// Contents: FSM state enum, default geometry/latency, word-index width helper.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEFAULT_DEPTH   = 256;
    localparam int DEFAULT_LATENCY = 4;

    // Bits needed to index DEPTH words; never narrower than one bit.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_resp_array.sv
// rtl/mem_resp_array.sv - DEPTH x 32 storage, synchronous write, combinational read
// Ports: clk_i; we_i/waddr_i/wdata_i write port; raddr_i/rdata_o read port.
module mem_resp_array #(
    parameter int DEPTH = 256,
    parameter int IW    = 8
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [IW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [IW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem [DEPTH];

    // No reset: contents survive a reset of the responder.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Guard for non-power-of-two depths; out-of-range reads are flagged as
    // errors upstream and their data is discarded anyway.
    assign rdata_o = (32'(raddr_i) < DEPTH) ? mem[raddr_i] : '0;

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - fixed-latency request/ack memory responder
// Ports: clk_i, rst_i (sync, active-high); req_i/we_i/addr_i/wdata_i request;
//        ack_o one-cycle completion, rdata_o read data, err_o error in ack cycle,
//        busy_o stall indication to the initiator.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        busy_o
);

    localparam int IW = idx_width(DEPTH);
    // WAIT covers LATENCY-1 cycles, counting down from LATENCY-2 to 0.
    localparam logic [3:0] CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    state_t      state;
    state_t      state_nx;
    logic [3:0]  cnt;
    logic        we_q;
    logic        err_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;

    logic        accept;
    logic        enter_resp;
    logic        cur_we;
    logic [31:0] cur_addr;
    logic [31:0] cur_index;
    logic        cur_err;
    logic        mem_we;
    logic [31:0] mem_rdata;

    assign accept     = (state == IDLE) && req_i;
    assign enter_resp = (state_nx == RESP) && (state != RESP);

    // With LATENCY=1 the read happens on the acceptance edge itself, so the
    // live request fields stand in for the not-yet-captured ones.
    assign cur_we    = (state == IDLE) ? we_i   : we_q;
    assign cur_addr  = (state == IDLE) ? addr_i : addr_q;
    assign cur_index = {2'b00, cur_addr[31:2]};
    assign cur_err   = (cur_addr[1:0] != 2'b00) || (cur_index >= 32'(DEPTH));

    mem_resp_array #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (mem_we),
        .waddr_i (addr_q[IW+1:2]),
        .wdata_i (wdata_q),
        .raddr_i (cur_addr[IW+1:2]),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                we_q    <= we_i;
                err_q   <= cur_err;
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
                cnt     <= CNT_LOAD;
            end else if ((state == WAIT) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            if (enter_resp && !cur_we) begin
                rdata_q <= cur_err ? 32'd0 : mem_rdata;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req_i) state_nx = (LATENCY == 1) ? RESP : WAIT;
            WAIT:    if (cnt == 4'd0) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Reset in the RESP cycle suppresses both the ack and the write.
    always_comb begin
        ack_o  = (state == RESP) && !rst_i;
        err_o  = (state == RESP) && !rst_i && err_q;
        mem_we = (state == RESP) && !rst_i && we_q && !err_q;
        busy_o = (state != IDLE) || req_i;
    end

    assign rdata_o = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - bench for mem_responder at LATENCY 4 and 1
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst   [2];
    logic        req   [2];
    logic        we    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic        ack   [2];
    logic [31:0] rdata [2];
    logic        err   [2];
    logic        busy  [2];

    int lat [2] = '{4, 1};

    always #5 clk = ~clk;

    mem_responder #(.DEPTH(256), .LATENCY(4)) dut (
        .clk_i(clk), .rst_i(rst[0]), .req_i(req[0]), .we_i(we[0]),
        .addr_i(addr[0]), .wdata_i(wdata[0]), .ack_o(ack[0]),
        .rdata_o(rdata[0]), .err_o(err[0]), .busy_o(busy[0]));

    mem_responder #(.DEPTH(256), .LATENCY(1)) dut1 (
        .clk_i(clk), .rst_i(rst[1]), .req_i(req[1]), .we_i(we[1]),
        .addr_i(addr[1]), .wdata_i(wdata[1]), .ack_o(ack[1]),
        .rdata_o(rdata[1]), .err_o(err[1]), .busy_o(busy[1]));

    // Reference model: plain word array per instance plus last read data.
    logic [31:0] mm  [2][256];
    logic [31:0] mrd [2];

    int vecs = 0;
    int errs = 0;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        bit          drop;
        bit          scr;
        bit          e;
        logic [31:0] rd;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Runs one transaction starting at a negedge in IDLE; returns at the
    // negedge of the cycle after the ack.
    task automatic txn(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input bit drop, input bit scr, input bit keep,
                       input bit use_exp, input bit exp_e, input logic [31:0] exp_rd);
        int          n;
        int          idx;
        bit          me;
        logic [31:0] mr;
        me  = (a[1:0] != 2'b00) || (a[31:2] >= 30'd256);
        idx = int'(a[9:2]);
        if (w) mr = mrd[k];
        else   mr = me ? 32'd0 : mm[k][idx];
        if (use_exp) begin
            me = exp_e;
            mr = exp_rd;
        end
        req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d;
        #1;
        chk("busy_on_req", 32'(busy[k]), 32'd1);
        @(posedge clk);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                if (drop) req[k] = 1'b0;
                if (scr) begin
                    addr[k]  = $urandom;
                    wdata[k] = $urandom;
                    we[k]    = ~w;
                end
            end
            if (!ack[k]) begin
                chk("busy_in_flight", 32'(busy[k]), 32'd1);
                chk("err_without_ack", 32'(err[k]), 32'd0);
            end
        end while (!ack[k] && n < 20);
        chk("ack_latency", n, lat[k]);
        chk("err_in_ack", 32'(err[k]), 32'(me));
        chk(w ? "rdata_kept_on_write" : "read_data", rdata[k], mr);
        if (w && !me) mm[k][idx] = d;
        if (!w) mrd[k] = mr;
        if (!keep) req[k] = 1'b0;
        @(negedge clk);
        chk("ack_single_pulse", 32'(ack[k]), 32'd0);
        chk("err_after_ack", 32'(err[k]), 32'd0);
        chk("busy_after_ack", 32'(busy[k]), 32'(req[k]));
    endtask

    initial begin
        int          r;
        logic [31:0] a;

        tbl[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 0, 0, 0, 32'h0};
        tbl[1]  = '{1'b0, 32'h10,  32'h0,        0, 0, 0, 32'hDEADBEEF};
        tbl[2]  = '{1'b1, 32'h0,   32'h11111111, 0, 0, 0, 32'hDEADBEEF};
        tbl[3]  = '{1'b0, 32'h13,  32'h0,        0, 0, 1, 32'h0};
        tbl[4]  = '{1'b1, 32'h400, 32'h99,       0, 0, 1, 32'h0};
        tbl[5]  = '{1'b0, 32'h0,   32'h0,        0, 0, 0, 32'h11111111};
        tbl[6]  = '{1'b1, 32'h8,   32'h1234,     1, 0, 0, 32'h11111111};
        tbl[7]  = '{1'b0, 32'h8,   32'h0,        0, 0, 0, 32'h1234};
        tbl[8]  = '{1'b1, 32'h20,  32'hABCD,     0, 1, 0, 32'h1234};
        tbl[9]  = '{1'b0, 32'h20,  32'h0,        0, 1, 0, 32'hABCD};
        tbl[10] = '{1'b1, 32'hC,   32'hCAFE0000, 0, 0, 0, 32'hABCD};
        tbl[11] = '{1'b1, 32'h3FC, 32'h77,       0, 0, 0, 32'hABCD};
        tbl[12] = '{1'b0, 32'h3FC, 32'h0,        0, 0, 0, 32'h77};

        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; req[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
            mrd[k] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("reset_ack", 32'(ack[k]), 32'd0);
            chk("reset_err", 32'(err[k]), 32'd0);
            chk("reset_busy", 32'(busy[k]), 32'd0);
            chk("reset_rdata", rdata[k], 32'd0);
            rst[k] = 1'b0;
        end
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            txn(0, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].drop, tbl[i].scr, 1'b0,
                1'b1, tbl[i].e, tbl[i].rd);
        end

        // Reset lands in the RESP cycle of a write: no ack, no write.
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'hC; wdata[0] = 32'h55;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b1; req[0] = 1'b0;
        #1;
        chk("ack_masked_by_reset", 32'(ack[0]), 32'd0);
        chk("err_masked_by_reset", 32'(err[0]), 32'd0);
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        @(negedge clk);
        chk("post_reset_ack", 32'(ack[0]), 32'd0);
        chk("post_reset_err", 32'(err[0]), 32'd0);
        chk("post_reset_busy", 32'(busy[0]), 32'd0);
        chk("post_reset_rdata", rdata[0], 32'd0);
        mrd[0] = 32'd0;
        txn(0, 1'b0, 32'hC, 32'h0, 0, 0, 0, 1'b1, 1'b0, 32'hCAFE0000);

        // LATENCY=1 back-to-back reads with req held between them.
        txn(1, 1'b1, 32'h0, 32'hA0A0A0A0, 0, 0, 0, 1'b1, 1'b0, 32'h0);
        txn(1, 1'b1, 32'h4, 32'hB1B1B1B1, 0, 0, 0, 1'b1, 1'b0, 32'h0);
        txn(1, 1'b0, 32'h0, 32'h0,        0, 0, 1, 1'b1, 1'b0, 32'hA0A0A0A0);
        txn(1, 1'b0, 32'h4, 32'h0,        0, 0, 0, 1'b1, 1'b0, 32'hB1B1B1B1);

        // Preload every word the random phase may read, then randomize.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 12; i++) begin
                a = (i < 8) ? 32'(i) * 4 : 32'(244 + i) * 4;
                txn(k, 1'b1, a, $urandom, 0, 0, 0, 1'b0, 1'b0, 32'h0);
            end
            for (int i = 0; i < 40; i++) begin
                r = $urandom_range(0, 9);
                if (r < 6)       a = 32'($urandom_range(0, 7)) * 4;
                else if (r == 6) a = 32'($urandom_range(252, 255)) * 4;
                else if (r == 7) a = 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(1, 3));
                else if (r == 8) a = 32'($urandom_range(256, 1023)) * 4;
                else             a = ($urandom & 32'hFFFF_FFFC) | 32'h8000_0000;
                txn(k, 1'($urandom_range(0, 1)), a, $urandom,
                    1'($urandom_range(0, 1)), (k == 0) && ($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 1)), 1'b0, 1'b0, 32'h0);
            end
            req[k] = 1'b0;
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH, default 256, number of 32-bit words of storage.
REQ-002 Parameter LATENCY, default 4, cycles from request acceptance to ack_o; legal range 1..15.
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, synchronous and active-high.
REQ-005 req_i  input  1  initiator request strobe, held high until ack_o is seen.
REQ-006 we_i  input  1  1 = write, 0 = read; sampled with req_i.
REQ-007 addr_i  input  32  byte address; word index = addr_i[31:2].
REQ-008 wdata_i  input  32  write data; sampled with req_i.
REQ-009 ack_o  output  1  one-cycle completion pulse.
REQ-010 rdata_o  output  32  read data; valid in the ack_o cycle of a read.
REQ-011 err_o  output  1  error flag; valid only in the ack_o cycle.
REQ-012 busy_o  output  1  high while a transaction is in flight; the initiator uses it as a stall source.

Function
REQ-013 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-014 In IDLE with req_i=1, the block SHALL capture we_i, addr_i and wdata_i at that edge and leave IDLE.
REQ-015 Input changes after capture SHALL be ignored until the next acceptance.
REQ-016 Transition from IDLE SHALL go to RESP if LATENCY=1; otherwise it SHALL go to WAIT with the down-counter loaded to LATENCY-2.
REQ-017 WAIT SHALL decrement the counter each cycle and move to RESP on the cycle the counter reads 0.
REQ-018 ack_o SHALL be high exactly LATENCY cycles after the acceptance cycle, for exactly one cycle (state RESP), then the FSM SHALL return to IDLE.
REQ-019 In IDLE, req_i=0 SHALL keep the FSM in IDLE with ack_o=0.
REQ-020 req_i high in the IDLE cycle after RESP SHALL be treated as a new request, giving back-to-back throughput of one transaction per LATENCY+1 cycles.
REQ-021 req_i deasserted during WAIT SHALL NOT abort the transaction; it SHALL still complete and acknowledge.
REQ-022 busy_o SHALL be high in WAIT and RESP, and in IDLE when req_i=1; otherwise busy_o SHALL be 0.
REQ-023 A read SHALL register the word mem[index] onto rdata_o on the edge entering RESP.
REQ-024 rdata_o SHALL hold its value until the next read completes.
REQ-025 A write SHALL update mem[index] on the edge leaving RESP, so a read issued immediately afterwards returns the new data.
REQ-026 A read SHALL NOT change memory, and a write SHALL leave rdata_o unchanged.
REQ-027 A request is erroneous if addr_i[1:0]!=0 or index>=DEPTH.
REQ-028 An erroneous request SHALL still ack after LATENCY cycles with err_o=1, SHALL NOT write memory, and SHALL drive rdata_o to 0 for a read.
REQ-029 err_o SHALL be 0 in every cycle in which ack_o=0.

Reset
REQ-030 rst_i=1 at an edge SHALL force IDLE and clear the counter, ack_o, err_o, busy_o's registered terms and rdata_o to 0.
REQ-031 rst_i SHALL take priority over every other event in the same cycle.
REQ-032 A reset during WAIT or RESP SHALL discard the pending transaction: no ack_o and no memory write, including a write in RESP.
REQ-033 Storage contents SHALL NOT be cleared by reset.

Structure
REQ-034 Package mem_resp_pkg SHALL hold the state enum (IDLE, WAIT, RESP), the default DEPTH and LATENCY constants, and the word-index width function.
REQ-035 Storage SHALL be a single sub-module mem_resp_array (synchronous write, combinational read, DEPTH x 32); the FSM, counter and error check SHALL reside in mem_responder.

Verification
REQ-036 Scenario: reset, write 0xDEADBEEF to 0x10 with LATENCY=4, then read 0x10 -> ack_o high at cycle acceptance+4 each time; read returns 0xDEADBEEF with err_o=0.
REQ-037 Scenario: LATENCY=1, back-to-back reads of 0x0 and 0x4 with req_i held -> an ack_o pulse every 2 cycles, busy_o continuously high.
REQ-038 Scenario: read of 0x13 (misaligned), then write to 0x400 (index 256 with DEPTH=256) -> both ack with err_o=1; the read returns 0; a subsequent read of 0x0 is unchanged.
REQ-039 Scenario: write 0x1234 to 0x8, and req_i dropped one cycle after acceptance -> ack_o still pulses at acceptance+4; memory word 2 = 0x1234.
REQ-040 Scenario: write 0x55 to 0xC with rst_i asserted in the RESP cycle -> no ack_o; all outputs 0 next cycle; a later read of 0xC returns the prior contents.
REQ-041 Scenario: addr_i and wdata_i changed during WAIT -> the originally captured address and data are used.
